// File: rtl/vector_text_parser_pkg.sv
// Shared types and constants for the ASCII bin/hex vector parser.
package vec_text_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIN,
    ST_HEX,
    ST_SKIP,
    ST_OUT
  } state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_US    = 8'h5F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_B  = 8'h62;
  localparam logic [7:0] ASCII_LC_F  = 8'h66;
  localparam logic [7:0] ASCII_LC_H  = 8'h68;

  // Bits contributed by one digit: 4 for hex, 1 for binary.
  function automatic int unsigned digitBits(input logic isHex);
    return isHex ? 32'd4 : 32'd1;
  endfunction

endpackage

// File: rtl/vector_text_parser_if.sv
// Byte-in / vector-out valid-ready bundle of the vector text parser.
interface vector_text_parser_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_is_hex;
  logic             out_ovf;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_is_hex, out_ovf, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_is_hex, out_ovf, out_err, out_valid
  );
endinterface

// File: rtl/vector_text_parser_decode.sv
// Character classifier so the parser FSM never compares raw ASCII codes.
module ascii_digit_decode
  import vec_text_pkg::*;
(
  input  logic [7:0] i_char,
  input  logic       i_isHex,
  output logic [3:0] o_value,
  output logic       o_isDigit,
  output logic       o_isIgnore,
  output logic       o_isBlank,
  output logic       o_isNewline,
  output logic       o_isBinFmt,
  output logic       o_isHexFmt
);

  logic [7:0] w_lower;

  // Setting bit 5 folds upper-case letters onto lower-case ones.
  assign w_lower = i_char | 8'h20;

  // Digit value and validity depend on the format currently being parsed.
  always_comb begin
    o_value   = 4'd0;
    o_isDigit = 1'b0;
    if (i_char >= ASCII_ZERO && i_char <= ASCII_NINE) begin
      o_value   = i_char[3:0];
      o_isDigit = i_isHex || (i_char <= ASCII_ONE);
    end else if (i_isHex && w_lower >= ASCII_LC_A && w_lower <= ASCII_LC_F) begin
      o_value   = w_lower[3:0] + 4'd9;
      o_isDigit = 1'b1;
    end
  end

  assign o_isIgnore  = (i_char == ASCII_US) || (i_char == ASCII_CR);
  assign o_isBlank   = (i_char == ASCII_SPACE) || (i_char == ASCII_CR);
  assign o_isNewline = (i_char == ASCII_LF);
  assign o_isBinFmt  = (w_lower == ASCII_LC_B);
  assign o_isHexFmt  = (w_lower == ASCII_LC_H);

endmodule

// File: rtl/vector_text_parser.sv
// Reassembles one "b..."/"h..." text line into a WIDTH-bit vector.
module vector_text_parser
  import vec_text_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_text_parser_if.slave  bus
);

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_acc, w_accNext;
  logic             r_ovf, w_ovfNext;
  logic             r_isHex, w_isHexNext;
  logic             r_err, w_errNext;
  logic [7:0]       r_count, w_countNext;

  logic [WIDTH-1:0] r_outData, w_outDataNext;
  logic             r_outIsHex, w_outIsHexNext;
  logic             r_outOvf, w_outOvfNext;
  logic             r_outErr, w_outErrNext;
  logic             w_load;

  logic             w_accept;
  logic             w_inHex;
  logic [3:0]       w_value;
  logic             w_isDigit, w_isIgnore, w_isBlank, w_isNewline;
  logic             w_isBinFmt, w_isHexFmt;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_lost;

  assign w_inHex  = (r_state == ST_HEX);
  assign w_accept = bus.in_valid && bus.in_ready;

  ascii_digit_decode u_decode (
    .i_char      (bus.in_data),
    .i_isHex     (w_inHex),
    .o_value     (w_value),
    .o_isDigit   (w_isDigit),
    .o_isIgnore  (w_isIgnore),
    .o_isBlank   (w_isBlank),
    .o_isNewline (w_isNewline),
    .o_isBinFmt  (w_isBinFmt),
    .o_isHexFmt  (w_isHexFmt)
  );

  // The new digit enters at the LSB; whatever falls off the top is kept
  // aside so a nonzero loss can flag overflow while leading zeros cannot.
  assign w_shifted = (r_acc << digitBits(w_inHex)) | {{(WIDTH-4){1'b0}}, w_value};
  assign w_lost    = r_acc >> (WIDTH - digitBits(w_inHex));

  // Next-state, accumulator and result-capture decisions for each accepted character.
  always_comb begin
    w_stateNext    = r_state;
    w_accNext      = r_acc;
    w_ovfNext      = r_ovf;
    w_isHexNext    = r_isHex;
    w_errNext      = r_err;
    w_countNext    = r_count;
    w_load         = 1'b0;
    w_outDataNext  = r_outData;
    w_outIsHexNext = r_outIsHex;
    w_outOvfNext   = r_outOvf;
    w_outErrNext   = r_outErr;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_isBinFmt || w_isHexFmt) begin
            w_stateNext = w_isHexFmt ? ST_HEX : ST_BIN;
            w_accNext   = '0;
            w_ovfNext   = 1'b0;
            w_isHexNext = w_isHexFmt;
            w_errNext   = 1'b0;
            w_countNext = 8'd0;
          end else if (!(w_isBlank || w_isNewline)) begin
            w_stateNext = ST_SKIP;
            w_isHexNext = 1'b0;
            w_errNext   = 1'b1;
          end
        end
      end

      ST_BIN, ST_HEX: begin
        if (w_accept) begin
          if (w_isNewline) begin
            w_stateNext    = ST_OUT;
            w_load         = 1'b1;
            w_outIsHexNext = w_inHex;
            if (r_count == 8'd0) begin
              w_outDataNext = '0;
              w_outOvfNext  = 1'b0;
              w_outErrNext  = 1'b1;
            end else begin
              w_outDataNext = r_acc;
              w_outOvfNext  = r_ovf;
              w_outErrNext  = 1'b0;
            end
          end else if (w_isDigit) begin
            w_accNext = w_shifted;
            w_ovfNext = r_ovf || (|w_lost);
            if (r_count != 8'hFF) begin
              w_countNext = r_count + 8'd1;
            end
          end else if (!w_isIgnore) begin
            w_stateNext = ST_SKIP;
            w_errNext   = 1'b1;
          end
        end
      end

      ST_SKIP: begin
        if (w_accept && w_isNewline) begin
          w_stateNext    = ST_OUT;
          w_load         = 1'b1;
          w_outDataNext  = '0;
          w_outIsHexNext = r_isHex;
          w_outOvfNext   = 1'b0;
          w_outErrNext   = 1'b1;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          w_stateNext = ST_IDLE;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State, token bookkeeping and the result register; results change only on entry to OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_isHex    <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= 8'd0;
      r_outData  <= '0;
      r_outIsHex <= 1'b0;
      r_outOvf   <= 1'b0;
      r_outErr   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_acc   <= w_accNext;
      r_ovf   <= w_ovfNext;
      r_isHex <= w_isHexNext;
      r_err   <= w_errNext;
      r_count <= w_countNext;
      if (w_load) begin
        r_outData  <= w_outDataNext;
        r_outIsHex <= w_outIsHexNext;
        r_outOvf   <= w_outOvfNext;
        r_outErr   <= w_outErrNext;
      end
    end
  end

  assign bus.in_ready   = (r_state != ST_OUT);
  assign bus.out_valid  = (r_state == ST_OUT);
  assign bus.out_data   = r_outData;
  assign bus.out_is_hex = r_outIsHex;
  assign bus.out_ovf    = r_outOvf;
  assign bus.out_err    = r_outErr;

endmodule

// File: tb/tb_vector_text_parser.sv
// Directed bench for vector_text_parser: table of whole lines plus
// hand-written back-pressure and mid-token reset sequences.
module tb_vector_text_parser;

  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checkCount  = 0;
  int passCount   = 0;
  int resultCount = 0;

  always #5 clk = ~clk;

  vector_text_parser_if #(.WIDTH(WIDTH)) bus ();

  vector_text_parser #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       text;
    logic [31:0] data;
    logic        isHex;
    logic        ovf;
    logic        err;
    bit          chkFlags;
  } vec_t;

  vec_t vecs[$];

  // Count every result handshake so lost or extra tokens show up.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) resultCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Starts at a negedge; returns at the negedge after the char was taken.
  task automatic sendChar(input logic [7:0] c);
    int waits;
    waits = 0;
    bus.in_data  = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) checkOutput("in_ready timeout", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int waits;
    waits = 0;
    while (!bus.out_valid && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    checkOutput({name, " out_valid"}, {31'b0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rcBefore;

    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    vecs.push_back('{"b1011\n",                                          32'h0000000B, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"hDEAD_beef\r\n",                                   32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"h1_0000_0000\n",                                   32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"h0_0000_0001\n",                                   32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"hx12\n",                                           32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"b\n",                                              32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"z\n",                                              32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{" \r\nH7f\n",                                       32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"b12\n",                                            32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"B1111_1111_1111_1111_1111_1111_1111_1111_1\n",     32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"b0000_0000_0000_0000_0000_0000_0000_0000_0001\n",  32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1});

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid",  {31'b0, bus.out_valid},  32'd0);
    checkOutput("reset out_data",   bus.out_data,            32'd0);
    checkOutput("reset out_is_hex", {31'b0, bus.out_is_hex}, 32'd0);
    checkOutput("reset out_ovf",    {31'b0, bus.out_ovf},    32'd0);
    checkOutput("reset out_err",    {31'b0, bus.out_err},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Table of complete lines, consumer always ready
    bus.out_ready = 1'b1;
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].text);
      checkOutput($sformatf("vec%0d out_valid", k), {31'b0, bus.out_valid}, 32'd1);
      checkOutput($sformatf("vec%0d in_ready",  k), {31'b0, bus.in_ready},  32'd0);
      checkOutput($sformatf("vec%0d out_data",  k), bus.out_data,           vecs[k].data);
      checkOutput($sformatf("vec%0d out_err",   k), {31'b0, bus.out_err},   {31'b0, vecs[k].err});
      if (vecs[k].chkFlags) begin
        checkOutput($sformatf("vec%0d out_is_hex", k), {31'b0, bus.out_is_hex}, {31'b0, vecs[k].isHex});
        checkOutput($sformatf("vec%0d out_ovf",    k), {31'b0, bus.out_ovf},    {31'b0, vecs[k].ovf});
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d done", k), {31'b0, bus.out_valid}, 32'd0);
    end

    // Back-pressure: two tokens streamed back to back, consumer stalls first result
    bus.out_ready = 1'b0;
    rcBefore = resultCount;
    fork
      applyStimulus("b1\nb10\n");
      begin
        waitValid("bp first");
        for (int c = 0; c < 5; c++) begin
          checkOutput($sformatf("bp hold%0d out_valid", c), {31'b0, bus.out_valid}, 32'd1);
          checkOutput($sformatf("bp hold%0d in_ready",  c), {31'b0, bus.in_ready},  32'd0);
          checkOutput($sformatf("bp hold%0d out_data",  c), bus.out_data,           32'd1);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("bp after handshake out_valid", {31'b0, bus.out_valid}, 32'd0);
        waitValid("bp second");
        checkOutput("bp second out_data", bus.out_data,          32'd2);
        checkOutput("bp second out_err",  {31'b0, bus.out_err},  32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
      end
    join
    checkOutput("bp result count", resultCount - rcBefore, 32'd2);

    // Reset in the middle of a hex token
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       sendChar(8'h68);
        default: sendChar(8'h46);
      endcase
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid",  {31'b0, bus.out_valid},  32'd0);
    checkOutput("midreset out_data",   bus.out_data,            32'd0);
    checkOutput("midreset out_is_hex", {31'b0, bus.out_is_hex}, 32'd0);
    checkOutput("midreset out_ovf",    {31'b0, bus.out_ovf},    32'd0);
    checkOutput("midreset out_err",    {31'b0, bus.out_err},    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rcBefore = resultCount;
    applyStimulus("b1\n");
    checkOutput("postreset out_valid",  {31'b0, bus.out_valid},  32'd1);
    checkOutput("postreset out_data",   bus.out_data,            32'd1);
    checkOutput("postreset out_is_hex", {31'b0, bus.out_is_hex}, 32'd0);
    checkOutput("postreset out_err",    {31'b0, bus.out_err},    32'd0);
    repeat (3) @(negedge clk);
    checkOutput("postreset result count", resultCount - rcBefore, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
